ysyx_22050039_idu_pipe: RTL and testbench

- Pipelined RV64 decode stage: successor to the combinational IDU.
- Accepts instructions over a valid/ready handshake, reads a parametrised GPR file, and registers the decoded bundle into an output stage with its own valid/ready handshake.
- Tracks outstanding writes with a per-register scoreboard, stalls on RAW/WAW hazards, and takes a write-back port from EXU/WBU.
- Sits between IFU and EXU.

---
 rtl/ysyx_22050039_idu_pipe.sv | 178 +++++++++++++++++
 tb/tb_ysyx_22050039_idu_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_idu_pipe.sv
// ysyx_22050039_idu_pipe: pipelined RV64 decode stage (IFU -> IDU -> EXU).
// Decodes addi/jalr/auipc/lui/sd/jal/ebreak, reads a 2R1W GPR file, and
// registers the decoded bundle behind a valid/ready output stage. A
// per-register busy scoreboard stalls RAW/WAW hazards until write-back.
// Optional macro YSYX_22050039_IDU_BYPASS_EN enables same-cycle write-back
// forwarding into the register read ports.
module ysyx_22050039_idu_pipe #(
   parameter int XLEN     = 64,
   parameter int INST_LEN = 32,
   parameter int NR_REG   = 32,
   parameter int REG_SEL  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [INST_LEN-1:0] in_inst,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_src1,
   output logic [XLEN-1:0]     out_src2,
   output logic [XLEN-1:0]     out_imm,
   output logic [REG_SEL-1:0]  out_rd,
   output logic                out_rd_wen,
   output logic [2:0]          out_func,
   output logic                out_pc_wen,
   output logic [XLEN-1:0]     out_pc,
   input  logic                wb_en,
   input  logic [REG_SEL-1:0]  wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                flush
);

   localparam logic [2:0] F_ADDI = 3'd0, F_JALR = 3'd1, F_AUIPC = 3'd2,
                          F_LUI  = 3'd3, F_SD   = 3'd4, F_JAL   = 3'd5,
                          F_EBRK = 3'd6, F_ILL  = 3'd7;

   logic [XLEN-1:0]    gpr [NR_REG];
   logic [NR_REG-1:0]  busy, busy_nxt;

   logic [6:0]         opc;
   logic [2:0]         f3;
   logic [REG_SEL-1:0] rs1, rs2, rd;
   logic [XLEN-1:0]    imm_i, imm_s, imm_u, imm_j;
   logic [XLEN-1:0]    rdat1, rdat2;
   logic               byp1, byp2;

   logic [2:0]         d_func;
   logic [XLEN-1:0]    d_imm, d_src1, d_src2;
   logic               d_use1, d_use2, d_wen, d_pcw;
   logic               hz, accept;

   assign opc = in_inst[6:0];
   assign f3  = in_inst[14:12];
   assign rd  = in_inst[11:7];
   assign rs1 = in_inst[19:15];
   assign rs2 = in_inst[24:20];

   assign imm_i = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
   assign imm_j = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                   in_inst[20], in_inst[30:21], 1'b0};

`ifdef YSYX_22050039_IDU_BYPASS_EN
   // Same-cycle write-back is visible to the read ports and unblocks the scoreboard.
   assign byp1 = wb_en && (wb_rd == rs1) && (rs1 != '0);
   assign byp2 = wb_en && (wb_rd == rs2) && (rs2 != '0);
   assign rdat1 = (rs1 == '0) ? '0 : (byp1 ? wb_data : gpr[rs1]);
   assign rdat2 = (rs2 == '0) ? '0 : (byp2 ? wb_data : gpr[rs2]);
`else
   // No forwarding: a RAW consumer waits until the cycle after write-back.
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
   assign rdat1 = (rs1 == '0) ? '0 : gpr[rs1];
   assign rdat2 = (rs2 == '0) ? '0 : gpr[rs2];
`endif

   // Instruction decode: function code, immediate, operands and register usage.
   always_comb begin
      d_func = F_ILL;
      d_imm  = '0;
      d_src1 = '0;
      d_src2 = '0;
      d_use1 = 1'b0;
      d_use2 = 1'b0;
      d_wen  = 1'b0;
      d_pcw  = 1'b0;
      unique case (opc)
         7'b0010011: if (f3 == 3'b000) begin
            d_func = F_ADDI; d_imm = imm_i; d_src1 = rdat1; d_src2 = imm_i;
            d_use1 = 1'b1;   d_wen = (rd != '0);
         end
         7'b1100111: if (f3 == 3'b000) begin
            d_func = F_JALR; d_imm = imm_i; d_src1 = rdat1; d_src2 = imm_i;
            d_use1 = 1'b1;   d_wen = (rd != '0); d_pcw = 1'b1;
         end
         7'b0010111: begin
            d_func = F_AUIPC; d_imm = imm_u; d_src1 = imm_u; d_wen = (rd != '0);
         end
         7'b0110111: begin
            d_func = F_LUI; d_imm = imm_u; d_src1 = imm_u; d_wen = (rd != '0);
         end
         7'b0100011: if (f3 == 3'b011) begin
            d_func = F_SD; d_imm = imm_s; d_src1 = rdat1; d_src2 = rdat2;
            d_use1 = 1'b1; d_use2 = 1'b1;
         end
         7'b1101111: begin
            d_func = F_JAL; d_imm = imm_j; d_src1 = imm_j;
            d_wen  = (rd != '0); d_pcw = 1'b1;
         end
         7'b1110011: if (in_inst == 32'h0010_0073) d_func = F_EBRK;
         default: ;
      endcase
   end

   // Stall when a source is still pending or rd already has a write in flight.
   assign hz = (d_use1 && busy[rs1] && !byp1) ||
               (d_use2 && busy[rs2] && !byp2) ||
               (d_wen  && busy[rd]);

   assign in_ready = !rst && !flush && !hz && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Scoreboard next state: write-back and flush clear, a new reservation wins.
   always_comb begin
      busy_nxt = busy;
      if (wb_en) busy_nxt[wb_rd] = 1'b0;
      if (flush && out_valid && out_rd_wen) busy_nxt[out_rd] = 1'b0;
      if (accept && d_wen) busy_nxt[rd] = 1'b1;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= busy_nxt;
   end

   // GPR write port; x0 is never written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR_REG; i++) gpr[i] <= '0;
      end else if (wb_en && (wb_rd != '0)) begin
         gpr[wb_rd] <= wb_data;
      end
   end

   // Output stage: load on accept, hold while stalled, drop on flush or drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_src1   <= '0;
         out_src2   <= '0;
         out_imm    <= '0;
         out_rd     <= '0;
         out_rd_wen <= 1'b0;
         out_func   <= '0;
         out_pc_wen <= 1'b0;
         out_pc     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         out_src1   <= d_src1;
         out_src2   <= d_src2;
         out_imm    <= d_imm;
         out_rd     <= rd;
         out_rd_wen <= d_wen;
         out_func   <= d_func;
         out_pc_wen <= d_pcw;
         out_pc     <= in_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ysyx_22050039_idu_pipe.sv
// Scoreboard bench for ysyx_22050039_idu_pipe: expected bundles are queued on
// accept and compared when the output stage fires.
module tb_ysyx_22050039_idu_pipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_src1, out_src2, out_imm, out_pc, wb_data;
   logic [4:0]  out_rd, wb_rd;
   logic        out_rd_wen, out_pc_wen, wb_en, flush;
   logic [2:0]  out_func;

   typedef struct {
      logic [63:0] s1, s2, imm, pc;
      logic [4:0]  rd;
      logic        wen, pcw;
      logic [2:0]  func;
   } exp_t;

   exp_t        q[$];
   logic [63:0] rf [32];
   int          checks = 0, errors = 0;
   logic        acc_last;

   always #5 clk = ~clk;

   ysyx_22050039_idu_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_rd(out_rd),
      .out_rd_wen(out_rd_wen), .out_func(out_func), .out_pc_wen(out_pc_wen),
      .out_pc(out_pc), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rv(input logic [4:0] r);
      if (r == 0) return 64'd0;
`ifdef YSYX_22050039_IDU_BYPASS_EN
      if (wb_en && wb_rd == r) return wb_data;
`endif
      return rf[r];
   endfunction

   function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
      exp_t e;
      logic [63:0] ii, is, iu, ij;
      ii = {{52{i[31]}}, i[31:20]};
      is = {{52{i[31]}}, i[31:25], i[11:7]};
      iu = {{32{i[31]}}, i[31:12], 12'h000};
      ij = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      e.s1 = 0; e.s2 = 0; e.imm = 0; e.pc = pc; e.rd = i[11:7];
      e.wen = 0; e.pcw = 0; e.func = 3'd7;
      if (i[6:0] == 7'b0010011 && i[14:12] == 3'b000) begin
         e.func = 0; e.imm = ii; e.s1 = rv(i[19:15]); e.s2 = ii; e.wen = (i[11:7] != 0);
      end else if (i[6:0] == 7'b1100111 && i[14:12] == 3'b000) begin
         e.func = 1; e.imm = ii; e.s1 = rv(i[19:15]); e.s2 = ii; e.wen = (i[11:7] != 0); e.pcw = 1;
      end else if (i[6:0] == 7'b0010111) begin
         e.func = 2; e.imm = iu; e.s1 = iu; e.wen = (i[11:7] != 0);
      end else if (i[6:0] == 7'b0110111) begin
         e.func = 3; e.imm = iu; e.s1 = iu; e.wen = (i[11:7] != 0);
      end else if (i[6:0] == 7'b0100011 && i[14:12] == 3'b011) begin
         e.func = 4; e.imm = is; e.s1 = rv(i[19:15]); e.s2 = rv(i[24:20]);
      end else if (i[6:0] == 7'b1101111) begin
         e.func = 5; e.imm = ij; e.s1 = ij; e.wen = (i[11:7] != 0); e.pcw = 1;
      end else if (i == 32'h0010_0073) begin
         e.func = 6;
      end
      return e;
   endfunction

   // One cycle: settle, score the output/input handshakes, cross the edge.
   task automatic cyc();
      exp_t e;
      #1;
      acc_last = in_valid && in_ready;
      if (flush && out_valid) begin
         if (q.size() > 0) e = q.pop_front();
      end else if (out_valid && out_ready) begin
         if (q.size() == 0) chk("q_empty", 1, 0);
         else begin
            e = q.pop_front();
            chk("func", out_func, e.func);
            chk("src1", out_src1, e.s1);
            chk("src2", out_src2, e.s2);
            chk("imm", out_imm, e.imm);
            chk("rd", out_rd, e.rd);
            chk("rd_wen", out_rd_wen, e.wen);
            chk("pc_wen", out_pc_wen, e.pcw);
            chk("pc", out_pc, e.pc);
         end
      end
      if (acc_last) q.push_back(model(in_inst, in_pc));
      @(posedge clk);
      if (wb_en && wb_rd != 0) rf[wb_rd] = wb_data;
      @(negedge clk);
   endtask

   task automatic issue(input logic [31:0] i, input logic [63:0] pc);
      in_valid = 1; in_inst = i; in_pc = pc;
      acc_last = 0;
      for (int n = 0; n < 20 && !acc_last; n++) cyc();
      if (!acc_last) chk("issue_timeout", 0, 1);
      in_valid = 0;
   endtask

   task automatic wb(input logic [4:0] r, input logic [63:0] d);
      wb_en = 1; wb_rd = r; wb_data = d;
      cyc();
      wb_en = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 32; k++) rf[k] = 0;
      rst = 1; in_valid = 1; in_inst = 32'h0050_0093; in_pc = 64'h8000_0000;
      out_ready = 1; wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0;
      @(negedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      @(negedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_src1", out_src1, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_rd", out_rd, 0);
      chk("rst_pc", out_pc, 0);
      @(negedge clk);
      rst = 0;

      // 1: addi x1,x0,5 with one-cycle latency
      in_valid = 1; in_inst = 32'h0050_0093; in_pc = 64'h8000_0000;
      cyc();
      chk("t1_acc", acc_last, 1);
      in_valid = 0;
      #1 chk("t1_lat", out_valid, 1);
      cyc();

      // 2: RAW on x1 held until write-back
      in_valid = 1; in_inst = 32'h0010_8113; in_pc = 64'h8000_0004;
      for (int n = 0; n < 2; n++) begin
         #1 chk("t2_stall", in_ready, 0);
         cyc();
      end
      wb_en = 1; wb_rd = 1; wb_data = 5;
`ifdef YSYX_22050039_IDU_BYPASS_EN
      #1 chk("t2_byp_rdy", in_ready, 1);
      cyc();
      wb_en = 0;
`else
      #1 chk("t2_wb_rdy", in_ready, 0);
      cyc();
      wb_en = 0;
      #1 chk("t2_after_rdy", in_ready, 1);
      cyc();
`endif
      in_valid = 0;
      cyc();
      wb(2, 64'd6);

      // 3: back-pressure holds the bundle and blocks input
      out_ready = 0;
      issue(32'h0070_0313, 64'h8000_0100);
      in_valid = 1; in_inst = 32'h0000_1397; in_pc = 64'h8000_0104;
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("t3_rdy", in_ready, 0);
         chk("t3_vld", out_valid, 1);
         chk("t3_imm", out_imm, 7);
         chk("t3_pc", out_pc, 64'h8000_0100);
         cyc();
      end
      out_ready = 1;
      #1 chk("t3_release", in_ready, 1);
      cyc();
      in_valid = 0;
      #1 chk("t3_next_vld", out_valid, 1);
      cyc();
      wb(6, 64'd7);
      wb(7, 64'h1000);

      // 4: flush a held jal, its x1 reservation must be dropped
      out_ready = 0;
      issue(32'h0080_00EF, 64'h8000_0200);
      in_valid = 1; in_inst = 32'h0000_8193; in_pc = 64'h8000_0204;
      flush = 1;
      #1;
      chk("t4_flush_rdy", in_ready, 0);
      chk("t4_jal_func", out_func, 5);
      chk("t4_jal_imm", out_imm, 8);
      cyc();
      flush = 0;
      #1;
      chk("t4_vld_drop", out_valid, 0);
      chk("t4_no_stall", in_ready, 1);
      out_ready = 1;
      cyc();
      in_valid = 0;
      cyc();
      wb(3, 64'd5);

      // 5: illegal, ebreak, then rd=31 not reserved by the illegal word
      issue(32'hFFFF_FFFF, 64'h8000_0300);
      in_valid = 1; in_inst = 32'h0010_0073; in_pc = 64'h8000_0304;
      #1 chk("t5_ebrk_rdy", in_ready, 1);
      cyc();
      in_valid = 1; in_inst = 32'h0010_0F93; in_pc = 64'h8000_0308;
      #1 chk("t5_nostall", in_ready, 1);
      cyc();
      issue(32'hFFF0_0413, 64'h8000_030C);
      issue(32'h0011_3423, 64'h8000_0310);
      issue(32'hFFDF_F06F, 64'h8000_0314);
      cyc();
      cyc();
      wb(31, 64'd1);
      wb(8, 64'hFFFF_FFFF_FFFF_FFFF);

      // 6: writes to x0 are dropped, x0 reads zero
      wb(0, 64'hDEAD);
      wb_en = 1; wb_rd = 0; wb_data = 64'hDEAD;
      issue(32'h0000_0213, 64'h8000_0400);
      wb_en = 0;
      issue(32'h1234_52B7, 64'h8000_0404);
      cyc();
      cyc();
      wb(4, 64'd0);
      wb(5, 64'h1234_5000);
      cyc();

      chk("q_drain", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
